// File: rtl/pause_pkg.sv
// Shared types and helpers for the video pause controller.
package pause_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        DIMMED = 2'd2
    } pause_state_t;

    localparam int DIM_W    = 2;
    localparam int SEC_W    = 8;
    localparam int CHAN_MAX = 16;

    // Logical right shift of one colour channel, bits above width forced to zero.
    function automatic logic [CHAN_MAX-1:0] shr_chan(input logic [CHAN_MAX-1:0] value,
                                                     input logic [DIM_W-1:0]    shift,
                                                     input int unsigned         width);
        logic [CHAN_MAX-1:0] mask;
        mask = (width >= CHAN_MAX) ? '1 : ((CHAN_MAX'(1) << width) - 1'b1);
        return (value & mask) >> shift;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// DIV-cycle divider: counts while enabled, clr wins, one-cycle tick on wrap.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/video_pause_ctrl.sv
// Merges user/OSD/external pause into one CPU halt and dims the RGB stream after idle time.
// Define PAUSE_FADE_EN for a stepped quarter-second fade instead of a single dim step.
module video_pause_ctrl
    import pause_pkg::*;
#(
    parameter int RW        = 3,
    parameter int GW        = 3,
    parameter int BW        = 2,
    parameter int NREQ      = 2,
    parameter int TICK_DIV  = 20000000,
    parameter int DIM_SEC   = 10,
    parameter int FADE_LVLS = 2
) (
    input  logic                  clk_sys,
    input  logic                  RESET_n,
    input  logic                  ce_pix,
    input  logic                  user_button,
    input  logic                  osd_open,
    input  logic [NREQ-1:0]       pause_req,
    input  logic [1:0]            options,
    input  logic [RW+GW+BW-1:0]   rgb_in,
    output logic [RW+GW+BW-1:0]   rgb_out,
    output logic                  pause_cpu,
    output logic [DIM_W-1:0]      dim_level,
    output logic [1:0]            state
);
    localparam int CW = RW + GW + BW;

    logic             btn_q, armed_q, tog_q;
    logic             btn_edge, soft_pause, hard_pause, sec_tick;
    pause_state_t     state_q;
    logic [DIM_W-1:0] dim_q, dim_step;
    logic [SEC_W-1:0] sec_q;
    logic             pause_q;
    logic [CW-1:0]    rgb_q, rgb_d;

    // armed_q blocks a button already held when reset releases from counting as a press.
    assign btn_edge   = user_button & ~btn_q & armed_q;
    assign soft_pause = tog_q | (osd_open & options[0]);
    assign hard_pause = |pause_req;

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            btn_q   <= 1'b0;
            armed_q <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            btn_q   <= user_button;
            armed_q <= armed_q | ~user_button;
            tog_q   <= tog_q ^ btn_edge;
        end
    end

    tick_prescaler #(.DIV(TICK_DIV)) u_sec (
        .clk_i (clk_sys),
        .rst_ni(RESET_n),
        .clr_i (state_q != PAUSED),
        .en_i  (state_q == PAUSED),
        .tick_o(sec_tick)
    );

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n)
            sec_q <= '0;
        else if (state_q != PAUSED)
            sec_q <= '0;
        else if (sec_tick && sec_q != SEC_W'(DIM_SEC))
            sec_q <= sec_q + 1'b1;
    end

`ifdef PAUSE_FADE_EN
    localparam int QDIV = (TICK_DIV / 4 > 0) ? TICK_DIV / 4 : 1;
    logic fade_tick;

    tick_prescaler #(.DIV(QDIV)) u_fade (
        .clk_i (clk_sys),
        .rst_ni(RESET_n),
        .clr_i (state_q != DIMMED),
        .en_i  (state_q == DIMMED && options[1]),
        .tick_o(fade_tick)
    );

    always_comb begin
        dim_step = dim_q;
        if (dim_q == '0)
            dim_step = DIM_W'(1);
        else if (fade_tick && dim_q < DIM_W'(FADE_LVLS))
            dim_step = dim_q + 1'b1;
    end
`else
    assign dim_step = DIM_W'(1);
`endif

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= RUN;
            dim_q   <= '0;
            pause_q <= 1'b0;
        end else begin
            pause_q <= soft_pause | hard_pause;
            case (state_q)
                RUN: if (soft_pause) state_q <= PAUSED;
                PAUSED: begin
                    if (!soft_pause)
                        state_q <= RUN;
                    else if (sec_q == SEC_W'(DIM_SEC) && options[1]) begin
                        state_q <= DIMMED;
                        dim_q   <= DIM_W'(1);
                    end
                end
                DIMMED: begin
                    // Dropping dim_q with the state change keeps the next pixel undimmed.
                    if (!soft_pause) begin
                        state_q <= RUN;
                        dim_q   <= '0;
                    end else if (!options[1])
                        dim_q <= '0;
                    else
                        dim_q <= dim_step;
                end
                default: begin
                    state_q <= RUN;
                    dim_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rgb_d = {RW'(shr_chan(CHAN_MAX'(rgb_in[CW-1 -: RW]),      dim_q, RW)),
                 GW'(shr_chan(CHAN_MAX'(rgb_in[GW+BW-1 -: GW]),   dim_q, GW)),
                 BW'(shr_chan(CHAN_MAX'(rgb_in[BW-1:0]),          dim_q, BW))};
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n)    rgb_q <= '0;
        else if (ce_pix) rgb_q <= rgb_d;
    end

    assign rgb_out   = rgb_q;
    assign pause_cpu = pause_q;
    assign dim_level = dim_q;
    assign state     = state_q;

endmodule

// File: tb/tb_video_pause_ctrl.sv
// Directed bench for video_pause_ctrl with TICK_DIV=100, DIM_SEC=2, 3/3/2 RGB.
module tb_video_pause_ctrl;

`ifdef PAUSE_FADE_EN
    localparam logic [1:0] LV_MAX  = 2'd2;
    localparam logic [7:0] RGB_MAX = 8'h24;
`else
    localparam logic [1:0] LV_MAX  = 2'd1;
    localparam logic [7:0] RGB_MAX = 8'h6D;
`endif

    logic       clk_sys = 1'b0;
    logic       RESET_n;
    logic       ce_pix;
    logic       user_button;
    logic       osd_open;
    logic [1:0] pause_req;
    logic [1:0] options;
    logic [7:0] rgb_in;
    logic [7:0] rgb_out;
    logic       pause_cpu;
    logic [1:0] dim_level;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    video_pause_ctrl #(
        .RW(3), .GW(3), .BW(2), .NREQ(2),
        .TICK_DIV(100), .DIM_SEC(2), .FADE_LVLS(2)
    ) dut (
        .clk_sys    (clk_sys),
        .RESET_n    (RESET_n),
        .ce_pix     (ce_pix),
        .user_button(user_button),
        .osd_open   (osd_open),
        .pause_req  (pause_req),
        .options    (options),
        .rgb_in     (rgb_in),
        .rgb_out    (rgb_out),
        .pause_cpu  (pause_cpu),
        .dim_level  (dim_level),
        .state      (state)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic pc,
                           input logic [1:0] dl);
        chk({tag, ".state"}, {6'd0, state}, {6'd0, st});
        chk({tag, ".pause"}, {7'd0, pause_cpu}, {7'd0, pc});
        chk({tag, ".dim"}, {6'd0, dim_level}, {6'd0, dl});
    endtask

    initial begin
        RESET_n = 1'b0; ce_pix = 1'b1; user_button = 1'b0; osd_open = 1'b0;
        pause_req = 2'b00; options = 2'b11; rgb_in = 8'hFF;
        step(2);
        chk_all("reset", 2'd0, 1'b0, 2'd0);
        chk("reset.rgb", rgb_out, 8'h00);

        RESET_n = 1'b1;
        step(2);
        chk("run.rgb", rgb_out, 8'hFF);

        // single-cycle button pulse
        user_button = 1'b1; step(1); user_button = 1'b0;
        chk_all("press.e0", 2'd0, 1'b0, 2'd0);
        step(1);
        chk_all("press.e1", 2'd1, 1'b1, 2'd0);
        chk("press.rgb", rgb_out, 8'hFF);

        // dim after DIM_SEC seconds of pause
        step(200);
        chk("idle.200", {6'd0, state}, 8'd1);
        step(1);
        chk_all("dim.entry", 2'd2, 1'b1, 2'd1);
        step(1);
        chk("dim.rgb1", rgb_out, 8'h6D);
        step(23);
        chk("dim.lv_pre", {6'd0, dim_level}, 8'd1);
        step(1);
        chk("dim.lv_max", {6'd0, dim_level}, {6'd0, LV_MAX});
        step(1);
        chk("dim.rgb_max", rgb_out, RGB_MAX);

        // dim enable dropped while dimmed
        options = 2'b01; step(1);
        chk_all("dimoff", 2'd2, 1'b1, 2'd0);
        step(1);
        chk("dimoff.rgb", rgb_out, 8'hFF);
        options = 2'b11; step(1);
        chk("dimon.lv", {6'd0, dim_level}, 8'd1);

        // unpause from DIMMED
        user_button = 1'b1; step(1); user_button = 1'b0;
        chk("unp.e0", {6'd0, state}, 8'd2);
        step(1);
        chk_all("unp.e1", 2'd0, 1'b0, 2'd0);
        step(1);
        chk("unp.rgb", rgb_out, 8'hFF);

        // external request halts without dimming
        pause_req = 2'b10; step(1);
        chk_all("hard.e1", 2'd0, 1'b1, 2'd0);
        step(499);
        chk_all("hard.500", 2'd0, 1'b1, 2'd0);
        chk("hard.rgb", rgb_out, 8'hFF);
        pause_req = 2'b00; step(1);
        chk("hard.off", {7'd0, pause_cpu}, 8'd0);

        // OSD pause gated by options[0]
        osd_open = 1'b1; options = 2'b10; step(2);
        chk_all("osd.nopt", 2'd0, 1'b0, 2'd0);
        options = 2'b11; step(1);
        chk_all("osd.opt", 2'd1, 1'b1, 2'd0);
        step(201);
        chk_all("osd.dim", 2'd2, 1'b1, 2'd1);
        osd_open = 1'b0; step(1);
        chk_all("osd.close", 2'd0, 1'b0, 2'd0);

        // held button toggles once
        user_button = 1'b1; step(2);
        chk_all("hold.e2", 2'd1, 1'b1, 2'd0);
        step(998);
        chk_all("hold.1000", 2'd2, 1'b1, LV_MAX);
        user_button = 1'b0; step(2);
        user_button = 1'b1; step(2);
        chk_all("repress", 2'd0, 1'b0, 2'd0);

        // async reset from deepest dim, button held across release
        user_button = 1'b0; step(2);
        user_button = 1'b1; step(1); user_button = 1'b0; step(1);
        chk("rst.paused", {6'd0, state}, 8'd1);
        step(227);
        chk_all("rst.pre", 2'd2, 1'b1, LV_MAX);
        user_button = 1'b1;
        #2 RESET_n = 1'b0;
        #1;
        chk_all("rst.async", 2'd0, 1'b0, 2'd0);
        chk("rst.rgb", rgb_out, 8'h00);
        step(1);
        RESET_n = 1'b1;
        step(5);
        chk_all("rst.held", 2'd0, 1'b0, 2'd0);
        user_button = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
